// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: state encoding and stream framing constants.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to each session.
package program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int INSTR_W        = 28;

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/program_loader_instruction_assembler.sv
// Packs four little-endian stream bytes into one 28-bit instruction word.
// The top nibble of the fourth byte is dropped.
module instruction_assembler
  import program_loader_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStrobe,
  input  logic [7:0]         iByte,
  output logic               oWordDone,
  output logic [INSTR_W-1:0] oWord
);

  logic [1:0]         cnt_q;
  logic [23:0]        buf_q;
  logic               done_q;
  logic [INSTR_W-1:0] word_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_q  <= '0;
      buf_q  <= '0;
      done_q <= 1'b0;
      word_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (iStrobe) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == LAST_BYTE) begin
          word_q <= {iByte[3:0], buf_q};
          done_q <= 1'b1;
        end else begin
          buf_q <= {iByte, buf_q[23:8]};
        end
      end
    end
  end

  assign oWordDone = done_q;
  assign oWord     = word_q;

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: length header, packed instruction words, optional checksum.
// Feature macro: LOADER_CHECKSUM_EN enables the CHECK state and XOR accumulator.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic                  iByteValid,
  input  logic [7:0]            iByte,
  output logic                  oByteReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [INSTR_W-1:0]    oInstruction,
  output logic                  oCpuReset,
  output logic                  oDone,
  output logic                  oError
);

  state_e                state_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  err_q;
  logic                  cpurst_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            lenlo_q;
  logic [15:0]           len_q;
  logic [15:0]           words_q;
  logic [1:0]            bcnt_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic        xfer;
  logic        data_stb;
  logic [15:0] len_d;
  logic        last_word;

  assign xfer      = iByteValid && ready_q;
  assign data_stb  = xfer && (state_q == DATA);
  assign len_d     = {iByte, lenlo_q};
  assign last_word = (words_q == len_q - 16'd1);

  instruction_assembler u_asm (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStrobe   (data_stb),
    .iByte     (iByte),
    .oWordDone (oWriteEnable),
    .oWord     (oInstruction)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cpurst_q <= 1'b1;
      addr_q   <= '0;
      lenlo_q  <= '0;
      len_q    <= '0;
      words_q  <= '0;
      bcnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: begin
          if (iStart) begin
            state_q  <= LEN_LO;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cpurst_q <= 1'b1;
            addr_q   <= '0;
            words_q  <= '0;
            bcnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
          end
        end
        LEN_LO: begin
          if (xfer) begin
            lenlo_q <= iByte;
            state_q <= LEN_HI;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_q ^ iByte;
`endif
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_q <= len_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ iByte;
`endif
            if (len_d == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= CHECK;
`else
              state_q  <= DONE;
              ready_q  <= 1'b0;
              done_q   <= 1'b1;
              cpurst_q <= 1'b0;
`endif
            end else if (int'(len_d) > MAX_WORDS) begin
              state_q <= ERROR;
              ready_q <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (data_stb) begin
            bcnt_q <= bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q <= csum_q ^ iByte;
`endif
            // stop accepting once the final word is complete
            if (bcnt_q == LAST_BYTE && last_word)
              ready_q <= 1'b0;
          end
          if (oWriteEnable) begin
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            words_q <= words_q + 16'd1;
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= CHECK;
              ready_q <= 1'b1;
`else
              state_q  <= DONE;
              done_q   <= 1'b1;
              cpurst_q <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) begin
            ready_q <= 1'b0;
            if (iByte == csum_q) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              cpurst_q <= 1'b0;
            end else begin
              state_q <= ERROR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign oByteReady    = ready_q;
  assign oWriteAddress = addr_q;
  assign oCpuReset     = cpurst_q;
  assign oDone         = done_q;
  assign oError        = err_q;

endmodule
